// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcodes, FSM state encoding and flag/compare bit indices for alu_seq.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_seq_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_NOT = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_SHR = 4'd7;
    localparam logic [3:0] OP_SRA = 4'd8;
    localparam logic [3:0] OP_CMP = 4'd9;
    localparam logic [3:0] OP_MUL = 4'd10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit positions inside the registered flag vector
    localparam int FLAG_V    = 0;
    localparam int FLAG_CY   = 1;
    localparam int FLAG_ZERO = 2;
    localparam int FLAG_NEG  = 3;
    localparam int FLAG_ERR  = 4;
    localparam int FLAG_N    = 5;

    // Bit positions of the CMP result inside C
    localparam int CMP_LT = 0;
    localparam int CMP_EQ = 1;
    localparam int CMP_GT = 2;

endpackage

// File: rtl/alu_seq_mul.sv
// alu_seq_mul: iterative unsigned shift-add multiplier, 2*WIDTH-bit product.
// Latency: WIDTH steps after start_i; done_o is high during the last step with product_o valid.
// Backpressure: none; caller must not pulse start_i while busy_o is high.
module alu_seq_mul #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [2*WIDTH-1:0]   product_o
);
    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [2*WIDTH-1:0] prod_q, prod_d, prod_step;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [SHW-1:0]     cnt_q, cnt_d;
    logic               busy_q, busy_d;

    // product_o shows the value after the current step so the caller can
    // capture the final product on the same edge the last step completes.
    assign prod_step = prod_q + (mplier_q[0] ? mcand_q : '0);
    assign done_o    = busy_q && (cnt_q == CNT_LAST);
    assign busy_o    = busy_q;
    assign product_o = prod_step;

    // Next state: load operands on start, otherwise one shift-add step per cycle
    always_comb begin
        mcand_d  = mcand_q;
        prod_d   = prod_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        if (start_i) begin
            mcand_d  = {{WIDTH{1'b0}}, a_i};
            mplier_d = b_i;
            prod_d   = '0;
            cnt_d    = '0;
            busy_d   = 1'b1;
        end else if (busy_q) begin
            prod_d   = prod_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + SHW'(1);
            if (done_o) begin
                busy_d = 1'b0;
            end
        end
    end

    // Multiplier state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q  <= '0;
            prod_q   <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            prod_q   <= prod_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered WIDTH-bit ALU with V/Carry/Zero/Neg/Err flags; MUL built only with `define ALU_SEQ_MUL_EN.
// Latency: out_valid 1 cycle after acceptance; MUL WIDTH+1 cycles.
// Backpressure: one op in flight; in_ready low until the result is taken, outputs held while out_ready is low.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       Op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] C,
    output logic [WIDTH-1:0] C_hi,
    output logic             V,
    output logic             Carry,
    output logic             Zero,
    output logic             Neg,
    output logic             Err
);
    localparam int SHW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] W_LIM = WIDTH'(WIDTH);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   c_q, c_d, chi_q, chi_d;
    logic [FLAG_N-1:0]  flags_q, flags_d;

    logic [WIDTH-1:0]   alu_c;
    logic               alu_v, alu_cy, alu_err;
    logic [WIDTH:0]     add_sum, sub_sum, shl_t, shr_t;
    logic signed [WIDTH:0] sra_t;
    logic [SHW-1:0]     sh;
    logic               sh_big;
    logic               take_mul;

    logic               load;
    logic [WIDTH-1:0]   res_c, res_chi;
    logic               res_v, res_cy, res_err;

    // Shifts carry one guard bit so the last bit shifted out falls into
    // bit WIDTH (left) or bit 0 (right); a zero shift leaves the guard at 0.
    assign add_sum = {1'b0, A} + {1'b0, B};
    assign sub_sum = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};
    assign sh_big  = (B >= W_LIM);
    assign sh      = B[SHW-1:0];
    assign shl_t   = {1'b0, A} << sh;
    assign shr_t   = {A, 1'b0} >> sh;
    assign sra_t   = $signed({A, 1'b0}) >>> sh;

`ifdef ALU_SEQ_MUL_EN
    logic               mul_start, mul_busy, mul_done;
    logic [2*WIDTH-1:0] mul_prod;

    assign take_mul  = (Op == OP_MUL);
    assign in_ready  = (state_q == IDLE) && !mul_busy;
    assign mul_start = (state_q == IDLE) && in_valid && in_ready && take_mul;

    alu_seq_mul #(
        .WIDTH     (WIDTH)
    ) u_mul (
        .clk       (clk),
        .rst       (rst),
        .start_i   (mul_start),
        .a_i       (A),
        .b_i       (B),
        .busy_o    (mul_busy),
        .done_o    (mul_done),
        .product_o (mul_prod)
    );
`else
    assign take_mul = 1'b0;
    assign in_ready = (state_q == IDLE);
`endif

    // Single-cycle datapath: result and flags for every non-MUL opcode
    always_comb begin
        alu_c   = '0;
        alu_v   = 1'b0;
        alu_cy  = 1'b0;
        alu_err = 1'b0;
        case (Op)
            OP_ADD: begin
                alu_c  = add_sum[WIDTH-1:0];
                alu_cy = add_sum[WIDTH];
                alu_v  = (A[WIDTH-1] == B[WIDTH-1]) && (add_sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                alu_c  = sub_sum[WIDTH-1:0];
                alu_cy = sub_sum[WIDTH];
                alu_v  = (A[WIDTH-1] != B[WIDTH-1]) && (sub_sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_AND: alu_c = A & B;
            OP_OR:  alu_c = A | B;
            OP_XOR: alu_c = A ^ B;
            OP_NOT: alu_c = ~A;
            OP_SHL: begin
                if (!sh_big) begin
                    alu_c  = shl_t[WIDTH-1:0];
                    alu_cy = shl_t[WIDTH];
                end
            end
            OP_SHR: begin
                if (!sh_big) begin
                    alu_c  = shr_t[WIDTH:1];
                    alu_cy = shr_t[0];
                end
            end
            OP_SRA: begin
                if (sh_big) begin
                    alu_c = {WIDTH{A[WIDTH-1]}};
                end else begin
                    alu_c  = sra_t[WIDTH:1];
                    alu_cy = sra_t[0];
                end
            end
            OP_CMP: begin
                alu_c[CMP_LT] = (A < B);
                alu_c[CMP_EQ] = (A == B);
                alu_c[CMP_GT] = (A > B);
            end
`ifdef ALU_SEQ_MUL_EN
            OP_MUL: alu_c = '0;  // result is produced by the multiplier
`endif
            default: alu_err = 1'b1;
        endcase
    end

    // FSM next state and result capture; Zero/Neg always follow the captured C
    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        chi_d   = chi_q;
        flags_d = flags_q;
        load    = 1'b0;
        res_c   = '0;
        res_chi = '0;
        res_v   = 1'b0;
        res_cy  = 1'b0;
        res_err = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    if (take_mul) begin
                        state_d = EXEC;
                    end else begin
                        load    = 1'b1;
                        res_c   = alu_c;
                        res_v   = alu_v;
                        res_cy  = alu_cy;
                        res_err = alu_err;
                        state_d = DONE;
                    end
                end
            end
`ifdef ALU_SEQ_MUL_EN
            EXEC: begin
                if (mul_done) begin
                    load    = 1'b1;
                    res_c   = mul_prod[WIDTH-1:0];
                    res_chi = mul_prod[2*WIDTH-1:WIDTH];
                    res_cy  = |mul_prod[2*WIDTH-1:WIDTH];
                    state_d = DONE;
                end
            end
`endif
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (load) begin
            c_d                = res_c;
            chi_d              = res_chi;
            flags_d            = '0;
            flags_d[FLAG_V]    = res_v;
            flags_d[FLAG_CY]   = res_cy;
            flags_d[FLAG_ZERO] = (res_c == '0);
            flags_d[FLAG_NEG]  = res_c[WIDTH-1];
            flags_d[FLAG_ERR]  = res_err;
        end
    end

    // State and output registers; reset aborts any op in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            c_q     <= '0;
            chi_q   <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            chi_q   <= chi_d;
            flags_q <= flags_d;
        end
    end

    assign out_valid = (state_q == DONE);
    assign C         = c_q;
    assign C_hi      = chi_q;
    assign V         = flags_q[FLAG_V];
    assign Carry     = flags_q[FLAG_CY];
    assign Zero      = flags_q[FLAG_ZERO];
    assign Neg       = flags_q[FLAG_NEG];
    assign Err       = flags_q[FLAG_ERR];

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors for alu_seq (WIDTH=8) with a queue-based scoreboard.
// Latency: checks 1-cycle ops and WIDTH+1-cycle MUL (when ALU_SEQ_MUL_EN is defined).
// Backpressure: holds out_ready low to check output stability and ignored inputs.
module tb_alu_seq;
    import alu_seq_pkg::*;

    typedef struct packed {
        logic [7:0] c;
        logic [7:0] chi;
        logic [4:0] fl;   // {V, Carry, Zero, Neg, Err}
    } res_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] A, B;
    logic [3:0] Op;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] C, C_hi;
    logic       V, Carry, Zero, Neg, Err;

    int    n_checks = 0;
    int    n_fail   = 0;
    res_t  exp_q[$];
    string nm_q[$];

    alu_seq #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Op        (Op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .C         (C),
        .C_hi      (C_hi),
        .V         (V),
        .Carry     (Carry),
        .Zero      (Zero),
        .Neg       (Neg),
        .Err       (Err)
    );

    always #5 clk = ~clk;

    function automatic res_t observed();
        return {C, C_hi, V, Carry, Zero, Neg, Err};
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
        end
    endtask

    // Monitor: every completed output handshake is compared with the oldest expectation
    initial begin
        res_t got, e;
        string nm;
        forever begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                got = observed();
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_output: got 0x%0h expected no output", got);
                end else begin
                    e  = exp_q.pop_front();
                    nm = nm_q.pop_front();
                    if (got !== e) begin
                        n_fail++;
                        $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, e);
                    end
                end
            end
        end
    end

    // Issue one op, check its latency; the monitor checks the result
    task automatic run(input string nm, input logic [3:0] op, input logic [7:0] a,
                       input logic [7:0] b, input res_t exp, input int lat);
        int cyc;
        Op = op; A = a; B = b; in_valid = 1'b1;
        exp_q.push_back(exp);
        nm_q.push_back(nm);
        cyc = 0;
        @(negedge clk);
        while (!in_ready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0; A = 8'h5A; B = 8'hA5; Op = 4'd15;
        cyc = 1;
        @(negedge clk);
        while (!out_valid && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        chk({nm, "_latency"}, 32'(cyc), 32'(lat));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; Op = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_in_ready",  32'(in_ready),  32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_outputs",   32'(observed()), 32'd0);
        @(posedge clk);
        #1;

        //  name        op      A      B      {C,     C_hi,  V C Z N E}   latency
        run("add_ovf",  OP_ADD, 8'h7F, 8'h01, {8'h80, 8'h00, 5'b10010}, 1);
        run("sub_eq",   OP_SUB, 8'h05, 8'h05, {8'h00, 8'h00, 5'b01100}, 1);
        run("sub_brw",  OP_SUB, 8'h03, 8'h05, {8'hFE, 8'h00, 5'b00010}, 1);
        run("add_wrap", OP_ADD, 8'h80, 8'h80, {8'h00, 8'h00, 5'b11100}, 1);
        run("sub_ovf",  OP_SUB, 8'h80, 8'h01, {8'h7F, 8'h00, 5'b11000}, 1);
        run("and",      OP_AND, 8'hF0, 8'h3C, {8'h30, 8'h00, 5'b00000}, 1);
        run("or",       OP_OR,  8'hF0, 8'h0F, {8'hFF, 8'h00, 5'b00010}, 1);
        run("xor",      OP_XOR, 8'hFF, 8'h0F, {8'hF0, 8'h00, 5'b00010}, 1);
        run("not",      OP_NOT, 8'h0F, 8'hAA, {8'hF0, 8'h00, 5'b00010}, 1);
        run("sra_neg",  OP_SRA, 8'h90, 8'h02, {8'hE4, 8'h00, 5'b00010}, 1);
        run("sra_pos",  OP_SRA, 8'h74, 8'h03, {8'h0E, 8'h00, 5'b01000}, 1);
        run("sra_big",  OP_SRA, 8'h90, 8'h09, {8'hFF, 8'h00, 5'b00010}, 1);
        run("shl_1",    OP_SHL, 8'h81, 8'h01, {8'h02, 8'h00, 5'b01000}, 1);
        run("shl_0",    OP_SHL, 8'h81, 8'h00, {8'h81, 8'h00, 5'b00010}, 1);
        run("shl_w",    OP_SHL, 8'hFF, 8'h08, {8'h00, 8'h00, 5'b00100}, 1);
        run("shr_big",  OP_SHR, 8'hFF, 8'h09, {8'h00, 8'h00, 5'b00100}, 1);
        run("shr_1",    OP_SHR, 8'h81, 8'h01, {8'h40, 8'h00, 5'b01000}, 1);
        run("cmp_lt",   OP_CMP, 8'h03, 8'h05, {8'h01, 8'h00, 5'b00000}, 1);
        run("cmp_gt",   OP_CMP, 8'h09, 8'h04, {8'h04, 8'h00, 5'b00000}, 1);
        run("cmp_eq",   OP_CMP, 8'h07, 8'h07, {8'h02, 8'h00, 5'b00000}, 1);
        run("illegal",  4'd12,  8'h33, 8'h44, {8'h00, 8'h00, 5'b00101}, 1);
`ifdef ALU_SEQ_MUL_EN
        run("mul_ff",   OP_MUL, 8'hFF, 8'hFF, {8'h01, 8'hFE, 5'b01000}, 9);
        run("mul_small",OP_MUL, 8'h03, 8'h05, {8'h0F, 8'h00, 5'b00000}, 9);
`else
        run("mul_off",  OP_MUL, 8'hFF, 8'hFF, {8'h00, 8'h00, 5'b00101}, 1);
        run("mul_off2", OP_MUL, 8'h03, 8'h05, {8'h00, 8'h00, 5'b00101}, 1);
`endif

        // Backpressure: result and flags frozen, in_ready low, new request ignored
        out_ready = 1'b0;
        exp_q.push_back({8'h30, 8'h00, 5'b00000});
        nm_q.push_back("bp_add");
        Op = OP_ADD; A = 8'h10; B = 8'h20; in_valid = 1'b1;
        @(posedge clk);
        #1;
        Op = OP_SUB; A = 8'hFF; B = 8'h01;
        repeat (5) begin
            @(negedge clk);
            chk("bp_out_valid", 32'(out_valid),  32'd1);
            chk("bp_in_ready",  32'(in_ready),   32'd0);
            chk("bp_hold",      32'(observed()), 32'({8'h30, 8'h00, 5'b00000}));
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_release_out_valid", 32'(out_valid), 32'd0);
        chk("bp_release_in_ready",  32'(in_ready),  32'd1);
        @(posedge clk);
        #1;

        // Reset four cycles into an op (EXEC for MUL builds, held DONE otherwise)
        out_ready = 1'b0;
`ifdef ALU_SEQ_MUL_EN
        Op = OP_MUL;
`else
        Op = OP_ADD;
`endif
        A = 8'h12; B = 8'h34; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_out_valid", 32'(out_valid),  32'd0);
        chk("rst_mid_in_ready",  32'(in_ready),   32'd1);
        chk("rst_mid_outputs",   32'(observed()), 32'd0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        run("post_rst_illegal", 4'd12, 8'h01, 8'h02, {8'h00, 8'h00, 5'b00101}, 1);
        run("post_rst_add",     OP_ADD, 8'h01, 8'h02, {8'h03, 8'h00, 5'b00000}, 1);

        repeat (4) @(posedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
